// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded processor: microaddress map, control word layout,
// ISA opcodes and the opcode-to-microroutine entry map.
package cpu_pkg;

   localparam int UA_W   = 8;
   localparam int CW_W   = 24;
   localparam int CTRL_W = 13;

   // Control word field positions
   localparam int CW_NEXT_LO  = 1;
   localparam int CW_NEXT_HI  = 8;
   localparam int CW_DISPATCH = 9;
   localparam int CW_CONDZ    = 10;
   localparam int CW_CTRL_LO  = 11;
   localparam int CW_CTRL_HI  = 23;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              condz;
      logic              dispatch;
      logic [UA_W-1:0]   next;
      logic              rsvd;
   } cw_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } seq_state_t;

   // Microaddresses
   localparam logic [UA_W-1:0] FETCH1  = 8'h00;
   localparam logic [UA_W-1:0] FETCH2  = 8'h01;
   localparam logic [UA_W-1:0] FETCH3  = 8'h02;
   localparam logic [UA_W-1:0] FETCH4  = 8'h03;
   localparam logic [UA_W-1:0] LDAC1   = 8'h04;
   localparam logic [UA_W-1:0] STAC1   = 8'h0C;
   localparam logic [UA_W-1:0] MOVACR  = 8'h10;
   localparam logic [UA_W-1:0] ADD     = 8'h12;
   localparam logic [UA_W-1:0] JMPZ    = 8'h14;
   localparam logic [UA_W-1:0] JMPZN   = 8'h16;
   localparam logic [UA_W-1:0] LDLDAC1 = 8'h18;
   localparam logic [UA_W-1:0] STSTAC1 = 8'h1A;
   localparam logic [UA_W-1:0] NOP     = 8'h1D;
   localparam logic [UA_W-1:0] END     = 8'h1E;

   // ISA opcodes
   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LDAC   = 8'h01;
   localparam logic [7:0] OP_STAC   = 8'h02;
   localparam logic [7:0] OP_MOVACR = 8'h03;
   localparam logic [7:0] OP_ADD    = 8'h04;
   localparam logic [7:0] OP_JMPZ   = 8'h05;
   localparam logic [7:0] OP_JMPZN  = 8'h06;
   localparam logic [7:0] OP_END    = 8'h07;
   localparam logic [7:0] OP_LDLDAC = 8'h08;
   localparam logic [7:0] OP_STSTAC = 8'h09;

   function automatic logic [UA_W-1:0] op2entry(input logic [7:0] op,
                                                input logic [UA_W-1:0] nop_addr);
      case (op)
         OP_NOP:    op2entry = NOP;
         OP_LDAC:   op2entry = LDAC1;
         OP_STAC:   op2entry = STAC1;
         OP_MOVACR: op2entry = MOVACR;
         OP_ADD:    op2entry = ADD;
         OP_JMPZ:   op2entry = JMPZ;
         OP_JMPZN:  op2entry = JMPZN;
         OP_END:    op2entry = END;
         OP_LDLDAC: op2entry = LDLDAC1;
         OP_STSTAC: op2entry = STSTAC1;
         default:   op2entry = nop_addr;
      endcase
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer <-> control store / datapath bundle; master is the sequencer side.
// No handshake: every signal is valid each cycle, stall is the only hold-off.
interface micro_sequencer_if import cpu_pkg::*; #(parameter int CNT_W = 16);
   logic                start;
   logic                stall;
   logic [7:0]          ir_op;
   logic                z_flag;
   cw_t                 cw;
   logic [UA_W-1:0]     uaddr;
   logic [CTRL_W-1:0]   ctrl;
   logic                halted;
   logic [CNT_W-1:0]    instr_count;

   modport master (
      input  start, stall, ir_op, z_flag, cw,
      output uaddr, ctrl, halted, instr_count
   );

   modport slave (
      output start, stall, ir_op, z_flag, cw,
      input  uaddr, ctrl, halted, instr_count
   );
endinterface

// File: rtl/micro_sequencer_dispatch_rom.sv
// Opcode -> microroutine entry address; purely combinational, zero latency.
// No backpressure; unmapped opcodes resolve to NOP_ADDR.
module dispatch_rom import cpu_pkg::*; #(
   parameter logic [UA_W-1:0] NOP_ADDR = NOP
) (
   input  logic [7:0]      op,
   output logic [UA_W-1:0] entry
);
   assign entry = op2entry(op, NOP_ADDR);
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered uaddr, next address combinational from cw/ir_op/z (1 uinstr/clk).
// Backpressure: stall freezes uaddr, counter and state and forces ctrl low; stall beats halt detection.
module micro_sequencer import cpu_pkg::*; #(
   parameter logic [UA_W-1:0] RESET_ADDR = 8'h00,
   parameter logic [UA_W-1:0] NOP_ADDR   = 8'h1D,
   parameter int              CNT_W      = 16
) (
   input logic                clk,
   input logic                rst,
   micro_sequencer_if.master  bus
);

   seq_state_t       state, state_n;
   logic [UA_W-1:0]  uaddr_q, uaddr_n;
   logic [UA_W-1:0]  next_addr, disp_addr;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             run_go;
   logic             self_loop;

   dispatch_rom #(.NOP_ADDR(NOP_ADDR)) u_dispatch_rom (
      .op    (bus.ir_op),
      .entry (disp_addr)
   );

   always_comb begin
      if (bus.cw.dispatch) begin
         next_addr = disp_addr;
      end else if (bus.cw.condz) begin
         next_addr = {bus.z_flag, bus.cw.next[UA_W-2:0]};
      end else begin
         next_addr = bus.cw.next;
      end
   end

   // A plain jump to its own address is the END idiom
   assign self_loop = !bus.cw.dispatch && !bus.cw.condz && (bus.cw.next == uaddr_q);

   always_comb begin
      state_n = state;
      uaddr_n = uaddr_q;
      cnt_n   = cnt_q;
      run_go  = 1'b0;
      unique case (state)
         S_IDLE: begin
            uaddr_n = RESET_ADDR;
            if (bus.start) begin
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            if (!bus.stall) begin
               run_go  = 1'b1;
               uaddr_n = next_addr;
               if (bus.cw.dispatch) begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
               if (self_loop) begin
                  state_n = S_HALT;
               end
            end
         end
         S_HALT: ;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         uaddr_q <= RESET_ADDR;
         cnt_q   <= '0;
      end else begin
         state   <= state_n;
         uaddr_q <= uaddr_n;
         cnt_q   <= cnt_n;
      end
   end

   assign bus.uaddr       = uaddr_q;
   assign bus.ctrl        = run_go ? bus.cw.ctrl : '0;
   assign bus.halted      = (state == S_HALT);
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed walk through fetch/dispatch/branch/stall/halt/reset,
// then randomized control words against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   micro_sequencer_if #(.CNT_W(CW)) bus ();

   micro_sequencer #(
      .RESET_ADDR (8'h00),
      .NOP_ADDR   (8'h1D),
      .CNT_W      (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] tbl [256];

   // model state: 0 idle, 1 run, 2 halt
   int         m_mode;
   logic [7:0] m_ua;
   int         m_cnt;

   logic [23:0] cw_v;
   logic        stall_v, start_v, z_v;
   logic [7:0]  op_v;

   localparam logic [12:0] K = 13'h1ABC;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [12:0] ec;
      ec = (m_mode == 1 && !stall_v) ? cw_v[23:11] : 13'd0;
      chk("uaddr",       32'(bus.uaddr),       32'(m_ua));
      chk("ctrl",        32'(bus.ctrl),        32'(ec));
      chk("halted",      32'(bus.halted),      32'(m_mode == 2));
      chk("instr_count", 32'(bus.instr_count), 32'(m_cnt));
   endtask

   task automatic model_step();
      logic [7:0] nx;
      case (m_mode)
         0: if (start_v) m_mode = 1;
         1: if (!stall_v) begin
               if (cw_v[9]) begin
                  nx    = tbl[op_v];
                  m_cnt = (m_cnt + 1) % (1 << CW);
               end else if (cw_v[10]) begin
                  nx = {z_v, cw_v[7:1]};
               end else begin
                  nx = cw_v[8:1];
                  if (nx == m_ua) m_mode = 2;
               end
               m_ua = nx;
            end
         default: ;
      endcase
   endtask

   task automatic cycle(input logic [23:0] c, input logic s, input logic [7:0] o,
                        input logic z, input logic st);
      @(negedge clk);
      cw_v = c; stall_v = s; op_v = o; z_v = z; start_v = st;
      bus.cw = c; bus.stall = s; bus.ir_op = o; bus.z_flag = z; bus.start = st;
      #1 compare_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic async_reset();
      @(negedge clk);
      start_v = 1'b0; stall_v = 1'b0;
      bus.start = 1'b0; bus.stall = 1'b0;
      #2 rst = 1'b1;
      m_mode = 0; m_ua = 8'h00; m_cnt = 0;
      #1 compare_all();
      #1 rst = 1'b0;
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic logic [23:0] w_next(input logic [7:0] a, input logic [12:0] ct);
      return {ct, 1'b0, 1'b0, a, 1'b0};
   endfunction
   function automatic logic [23:0] w_disp(input logic [12:0] ct);
      return {ct, 1'b0, 1'b1, 8'h00, 1'b0};
   endfunction
   function automatic logic [23:0] w_br(input logic [7:0] a, input logic [12:0] ct);
      return {ct, 1'b1, 1'b0, a, 1'b0};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'h1D;
      tbl[8'h01] = 8'h04; tbl[8'h02] = 8'h0C; tbl[8'h03] = 8'h10;
      tbl[8'h04] = 8'h12; tbl[8'h05] = 8'h14; tbl[8'h06] = 8'h16;
      tbl[8'h07] = 8'h1E; tbl[8'h08] = 8'h18; tbl[8'h09] = 8'h1A;

      m_mode = 0; m_ua = 8'h00; m_cnt = 0;
      cw_v = w_next(8'h05, K); stall_v = 1'b0; start_v = 1'b0; z_v = 1'b0; op_v = 8'h00;
      bus.cw = cw_v; bus.stall = 1'b0; bus.start = 1'b0; bus.z_flag = 1'b0; bus.ir_op = 8'h00;

      #3;
      compare_all();
      chk("rst_uaddr", 32'(bus.uaddr), 32'h00);
      chk("rst_count", 32'(bus.instr_count), 32'h0);
      rst = 1'b0;

      // IDLE ignores control words
      cycle(w_next(8'h05, K), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_ctrl", 32'(bus.ctrl), 32'h0);
      cycle(w_next(8'h01, K), 1'b0, 8'h00, 1'b0, 1'b1);
      chk("start_uaddr", 32'(bus.uaddr), 32'h00);

      // fetch sequence and dispatch
      cycle(w_next(8'h01, K), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("fetch2", 32'(bus.uaddr), 32'h01);
      chk("run_ctrl", 32'(bus.ctrl), 32'(K));
      cycle(w_next(8'h02, K), 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(w_next(8'h03, K), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("fetch4", 32'(bus.uaddr), 32'h03);
      cycle(w_disp(K), 1'b0, 8'h01, 1'b0, 1'b0);
      chk("ldac_entry", 32'(bus.uaddr), 32'h04);
      chk("count1", 32'(bus.instr_count), 32'h1);

      // stall in the middle of LDAC
      cycle(w_next(8'h05, K), 1'b0, 8'h01, 1'b0, 1'b0);
      cycle(w_next(8'h06, K), 1'b0, 8'h01, 1'b0, 1'b0);
      cycle(w_next(8'h07, K), 1'b1, 8'h01, 1'b0, 1'b0);
      cycle(w_disp(K),        1'b1, 8'h01, 1'b0, 1'b0);
      cycle(w_next(8'h07, K), 1'b1, 8'h01, 1'b0, 1'b0);
      chk("stall_uaddr", 32'(bus.uaddr), 32'h06);
      chk("stall_ctrl", 32'(bus.ctrl), 32'h0);
      cycle(w_next(8'h07, K), 1'b0, 8'h01, 1'b0, 1'b0);
      chk("resume_uaddr", 32'(bus.uaddr), 32'h07);
      chk("stall_count", 32'(bus.instr_count), 32'h1);

      // unmapped opcode, then Z branches
      cycle(w_next(8'h00, K), 1'b0, 8'h01, 1'b0, 1'b0);
      cycle(w_disp(K), 1'b0, 8'hFF, 1'b0, 1'b0);
      chk("unmapped", 32'(bus.uaddr), 32'h1D);
      cycle(w_br(8'h1C, K), 1'b0, 8'hFF, 1'b1, 1'b0);
      chk("zbr_taken", 32'(bus.uaddr), 32'h9C);
      cycle(w_br(8'h1C, K), 1'b0, 8'hFF, 1'b0, 1'b0);
      chk("zbr_not", 32'(bus.uaddr), 32'h1C);

      // END: stall beats halt, then halt, then start ignored
      cycle(w_next(8'h1E, K), 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(w_next(8'h1E, K), 1'b1, 8'h00, 1'b0, 1'b0);
      chk("stall_no_halt", 32'(bus.halted), 32'h0);
      cycle(w_next(8'h1E, K), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("halted", 32'(bus.halted), 32'h1);
      chk("halt_uaddr", 32'(bus.uaddr), 32'h1E);
      chk("halt_ctrl", 32'(bus.ctrl), 32'h0);
      cycle(w_next(8'h05, K), 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(w_disp(K), 1'b0, 8'h01, 1'b0, 1'b1);
      chk("halt_hold", 32'(bus.uaddr), 32'h1E);
      chk("halt_count", 32'(bus.instr_count), 32'h2);

      // asynchronous reset while running at 0x9D
      async_reset();
      chk("rst_halted", 32'(bus.halted), 32'h0);
      cycle(w_next(8'h00, K), 1'b0, 8'h00, 1'b0, 1'b1);
      cycle(w_disp(K), 1'b0, 8'h02, 1'b0, 1'b0);
      chk("stac_entry", 32'(bus.uaddr), 32'h0C);
      cycle(w_br(8'h1D, K), 1'b0, 8'h02, 1'b1, 1'b0);
      chk("at_9d", 32'(bus.uaddr), 32'h9D);
      async_reset();
      chk("arst_uaddr", 32'(bus.uaddr), 32'h00);
      chk("arst_count", 32'(bus.instr_count), 32'h0);
      cycle(w_next(8'h05, K), 1'b0, 8'h00, 1'b0, 1'b0);
      chk("arst_idle", 32'(bus.uaddr), 32'h00);

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         logic [23:0] c;
         logic        s, st, z;
         logic [7:0]  o;
         if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
            async_reset();
         end else begin
            c = 24'($urandom);
            if ($urandom_range(0, 19) == 0) begin
               c[10:9] = 2'b00;
               c[8:1]  = m_ua;
            end
            s  = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 3) == 0);
            o  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            z  = 1'($urandom_range(0, 1));
            cycle(c, s, o, z, st);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
